// File: rtl/keypad_entry_if.sv
// Time-entry bus between the keypad producer and the oven controller.
interface keypad_entry_if;
    logic       enable;
    logic       entry_clr;
    logic [3:0] digit;
    logic       digit_valid;
    logic [3:0] mins;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       entry_nonzero;
    logic       time_valid;

    modport master (
        input  enable, entry_clr,
        output digit, digit_valid, mins, sec_tens, sec_ones, entry_nonzero, time_valid
    );

    modport slave (
        output enable, entry_clr,
        input  digit, digit_valid, mins, sec_tens, sec_ones, entry_nonzero, time_valid
    );
endinterface

// File: rtl/keypad_entry.sv
// Keypad debouncer and 3-digit time-entry shift register (mins, sec_tens, sec_ones).
// Optional KEYPAD_CLAMP_EN: clamp sec_tens > 5 to x:59 after each shift.
module keypad_entry #(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int CNT_W           = 4
) (
    input  logic        clock,
    input  logic        clearn,
    input  logic [9:0]  keypad,
    keypad_entry_if.master ent
);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);

    function automatic logic is_onehot(input logic [9:0] v);
        return (v != '0) && ((v & (v - 10'd1)) == '0);
    endfunction

    function automatic logic [3:0] enc(input logic [9:0] v);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < 10; i++)
            if (v[i]) r = 4'(i);
        return r;
    endfunction

    logic [9:0]       sync1, ks;
    logic [9:0]       key_code;
    logic [CNT_W-1:0] cnt;
    state_t           state;
    logic [3:0]       digit_r;
    logic             digit_valid_r;
    logic [3:0]       mins_r, tens_r, ones_r;
    logic             accept, emit;
    logic [3:0]       new_tens, new_ones;

    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            sync1 <= '0;
            ks    <= '0;
        end else begin
            sync1 <= keypad;
            ks    <= sync1;
        end
    end

    // The press is accepted on the edge that would bring cnt to DEBOUNCE_CYCLES.
    always_comb begin
        accept = (state == DEBOUNCE) && (ks == key_code) && (cnt >= CNT_LAST);
        emit   = accept && ent.enable;
    end

    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            state         <= IDLE;
            cnt           <= '0;
            key_code      <= '0;
            digit_r       <= '0;
            digit_valid_r <= 1'b0;
        end else begin
            digit_valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (is_onehot(ks)) begin
                        key_code <= ks;
                        cnt      <= CNT_W'(1);
                        state    <= DEBOUNCE;
                    end else if (ks != '0) begin
                        state <= HELD;
                    end
                end
                DEBOUNCE: begin
                    if (ks == '0) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (!is_onehot(ks)) begin
                        state <= HELD;
                    end else if (ks != key_code) begin
                        key_code <= ks;
                        cnt      <= CNT_W'(1);
                    end else if (accept) begin
                        cnt   <= CNT_DONE;
                        state <= HELD;
                        if (emit) begin
                            digit_valid_r <= 1'b1;
                            digit_r       <= enc(key_code);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (ks == '0) begin
                        cnt   <= CNT_W'(1);
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (ks != '0) begin
                        state <= HELD;
                    end else if (cnt >= CNT_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        new_tens = ones_r;
        new_ones = enc(key_code);
`ifdef KEYPAD_CLAMP_EN
        if (new_tens > 4'd5) begin
            new_tens = 4'd5;
            new_ones = 4'd9;
        end
`endif
    end

    // A clear wins over a simultaneous shift; the strobe still fires.
    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            mins_r <= '0;
            tens_r <= '0;
            ones_r <= '0;
        end else if (ent.entry_clr) begin
            mins_r <= '0;
            tens_r <= '0;
            ones_r <= '0;
        end else if (emit) begin
            mins_r <= tens_r;
            tens_r <= new_tens;
            ones_r <= new_ones;
        end
    end

    assign ent.digit         = digit_r;
    assign ent.digit_valid   = digit_valid_r;
    assign ent.mins          = mins_r;
    assign ent.sec_tens      = tens_r;
    assign ent.sec_ones      = ones_r;
    assign ent.entry_nonzero = |{mins_r, tens_r, ones_r};
`ifdef KEYPAD_CLAMP_EN
    assign ent.time_valid    = 1'b1;
`else
    assign ent.time_valid    = (tens_r <= 4'd5);
`endif

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry with DEBOUNCE_CYCLES=4.
module tb_keypad_entry;
    logic       clock = 1'b0;
    logic       clearn;
    logic [9:0] keypad;
    int         total = 0;
    int         bad   = 0;
    int         pulses = 0;
    logic [3:0] last_digit = '0;
    int         lat;
    int         p0;

    keypad_entry_if ifc();

    keypad_entry #(.DEBOUNCE_CYCLES(4), .CNT_W(4)) dut (
        .clock  (clock),
        .clearn (clearn),
        .keypad (keypad),
        .ent    (ifc)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (clearn && ifc.digit_valid) begin
            pulses     = pulses + 1;
            last_digit = ifc.digit;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check_reg(input string tag, input logic [3:0] m, input logic [3:0] t, input logic [3:0] o);
        check({tag, "_reg"}, {20'h0, ifc.mins, ifc.sec_tens, ifc.sec_ones}, {20'h0, m, t, o});
    endtask

    // Drives one key press and reports in how many clocks the strobe appeared (-1: none).
    task automatic press(input int k, input int hold, input int gap, output int l);
        l = -1;
        keypad = 10'(1 << k);
        for (int i = 1; i <= hold; i++) begin
            @(posedge clock);
            #1;
            if (ifc.digit_valid && l < 0) l = i;
        end
        keypad = '0;
        tick(gap);
    endtask

    initial begin
        clearn        = 1'b0;
        keypad        = '0;
        ifc.enable    = 1'b1;
        ifc.entry_clr = 1'b0;
        tick(3);
        check("rst_digit", 32'(ifc.digit), 32'd0);
        check("rst_dv", 32'(ifc.digit_valid), 32'd0);
        check_reg("rst", 4'd0, 4'd0, 4'd0);
        check("rst_nonzero", 32'(ifc.entry_nonzero), 32'd0);
        check("rst_tv", 32'(ifc.time_valid), 32'd1);
        clearn = 1'b1;
        tick(1);

        press(2, 20, 20, lat);
        check("lat_2", 32'(lat), 32'd6);
        press(5, 20, 20, lat);
        check("lat_5", 32'(lat), 32'd6);
        press(9, 20, 20, lat);
        check("lat_9", 32'(lat), 32'd6);
        check("pulses_259", 32'(pulses), 32'd3);
        check_reg("e259", 4'd2, 4'd5, 4'd9);
        check("tv_259", 32'(ifc.time_valid), 32'd1);
        check("nz_259", 32'(ifc.entry_nonzero), 32'd1);

        press(9, 20, 20, lat);
        press(9, 20, 20, lat);
`ifdef KEYPAD_CLAMP_EN
        // sec_tens never exceeds 5 once clamped, so mins can only inherit 5.
        check_reg("e_99", 4'd5, 4'd5, 4'd9);
        check("tv_99", 32'(ifc.time_valid), 32'd1);
`else
        check_reg("e_99", 4'd9, 4'd9, 4'd9);
        check("tv_99", 32'(ifc.time_valid), 32'd0);
`endif
        check("digit_99", 32'(ifc.digit), 32'd9);

        ifc.entry_clr = 1'b1;
        tick(1);
        ifc.entry_clr = 1'b0;
        check_reg("clr", 4'd0, 4'd0, 4'd0);
        check("clr_nz", 32'(ifc.entry_nonzero), 32'd0);

        p0 = pulses;
        for (int k = 0; k < 5; k++) begin
            keypad = (k % 2 == 0) ? 10'b0000001000 : 10'b0;
            tick(2);
        end
        tick(20);
        keypad = '0;
        tick(20);
        check("bounce_pulses", 32'(pulses - p0), 32'd1);
        check("bounce_digit", 32'(last_digit), 32'd3);
        check_reg("bounce", 4'd0, 4'd0, 4'd3);

        p0 = pulses;
        keypad = 10'b0000000110;
        tick(20);
        keypad = '0;
        tick(20);
        check("multi_pulses", 32'(pulses - p0), 32'd0);
        check_reg("multi", 4'd0, 4'd0, 4'd3);
        press(7, 20, 20, lat);
        check("lat_7", 32'(lat), 32'd6);
        check_reg("after_multi", 4'd0, 4'd3, 4'd7);

        p0 = pulses;
        ifc.enable = 1'b0;
        keypad = 10'b0000010000;
        tick(20);
        ifc.enable = 1'b1;
        tick(10);
        keypad = '0;
        tick(20);
        check("en_pulses", 32'(pulses - p0), 32'd0);
        check_reg("en", 4'd0, 4'd3, 4'd7);

        p0 = pulses;
        keypad = 10'b0100000000;
        tick(5);
        ifc.entry_clr = 1'b1;
        tick(1);
        ifc.entry_clr = 1'b0;
        check("clr8_dv", 32'(ifc.digit_valid), 32'd1);
        check("clr8_digit", 32'(ifc.digit), 32'd8);
        check_reg("clr8", 4'd0, 4'd0, 4'd0);
        tick(14);
        keypad = '0;
        tick(20);
        check("clr8_pulses", 32'(pulses - p0), 32'd1);

        press(1, 20, 20, lat);
        check_reg("pre_rst", 4'd0, 4'd0, 4'd1);
        keypad = 10'b0000100000;
        tick(3);
        clearn = 1'b0;
        #1;
        check("mid_rst_digit", 32'(ifc.digit), 32'd0);
        check("mid_rst_dv", 32'(ifc.digit_valid), 32'd0);
        check_reg("mid_rst", 4'd0, 4'd0, 4'd0);
        check("mid_rst_nz", 32'(ifc.entry_nonzero), 32'd0);
        @(posedge clock);
        #1;
        clearn = 1'b1;
        p0 = pulses;
        tick(20);
        keypad = '0;
        tick(20);
        check("rerun_pulses", 32'(pulses - p0), 32'd1);
        check("rerun_digit", 32'(ifc.digit), 32'd5);
        check_reg("rerun", 4'd0, 4'd0, 4'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
